piezo_drv: RTL and testbench
============================

Name: piezo_drv

Overview:
- Downstream output stage for the tune sequencer.
- Accepts note requests (period, duration) over a valid/ready handshake and buffers one note ahead, so consecutive notes play gap-free.
- Generates a 50% duty square wave on complementary piezo outputs, with break-before-make dead-time.
- Reports note completion back to the sequencer.

Parameters:
- FAST_SIM, 1, duration counter step: 16 when 1, 1 when 0.
- PERIOD_W, 15, note period width in clocks.
- DUR_W, 24, note duration width in clocks.
- DEAD, 4, dead-time cycles with both outputs low on every drive change.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-high reset.
- note_vld  in  1  note request valid.
- note_rdy  out  1  driver can accept a note.
- note_period  in  PERIOD_W  square-wave period in clocks; 0 = rest.
- note_dur  in  DUR_W  note length in clocks.
- stop  in  1  synchronous abort.
- piezo  out  1  high-side drive.
- piezo_n  out  1  low-side drive.
- busy  out  1  a note is active.
- note_done  out  1  one-cycle pulse when the active note completes.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: piezo=0, piezo_n=0, busy=0, note_done=0, note_rdy=0 while rst=1. Active and buffer entries are cleared. note_rdy=1 in the first cycle after rst falls.
- Storage: one active slot plus one buffer slot. note_rdy = !buffer_valid && !stop && !rst. A transfer happens when note_vld && note_rdy.
- FSM states: IDLE, PLAY.
  - IDLE: an accepted note loads directly into the active slot. PLAY starts next cycle with busy=1.
  - PLAY: an accepted note loads into the buffer.
  - Accept in the same cycle the active note finishes with an empty buffer: the new note becomes active next cycle, with no gap.
- Period counter:
  - pcnt runs 0..note_period-1, then wraps to 0.
  - Desired drive is HI while pcnt < note_period>>1, else LO.
  - Odd periods: the LO phase is one cycle longer.
- Rest: note_period < 2*DEAD+2, including 0, is a rest. Desired drive is OFF for the whole duration.
- Dead-time:
  - On any change of desired drive (OFF/HI/LO), both outputs are held low for DEAD cycles, then the new drive is applied.
  - pcnt keeps counting during dead-time.
  - piezo and piezo_n are never both 1 in any cycle.
  - Outputs are registered.
- Duration:
  - dcnt starts at 0 in the note's first active cycle and adds STEP each cycle, where STEP = FAST_SIM ? 16 : 1.
  - note_done pulses in the cycle where dcnt+STEP >= note_dur, compared in DUR_W+1 bits.
  - note_dur=0 completes in its first active cycle.
- Note completion:
  - Buffer valid: the buffer moves to active the next cycle, with pcnt=0 and dcnt=0.
  - Buffer empty: go to IDLE next cycle; busy=0 and desired drive is OFF.
- Latency: a note accepted in cycle N has busy=1 in N+1 and piezo=1 first in N+1+DEAD.
- stop: has priority over everything else.
  - Next cycle: IDLE, both slots cleared, both outputs 0, busy=0.
  - No note_done is produced for the aborted note.
  - A request offered together with stop is not accepted.
- rst mid-note: same result as stop, plus note_rdy=0 while rst is held.
- Simultaneous note_done and acceptance into an empty buffer: legal. The new note plays immediately after.

Decomposition:
- piezo_pkg holds:
  - drv_state_t, with IDLE and PLAY.
  - drive_t, with OFF, HI and LO.
  - Default widths PERIOD_W and DUR_W.
  - DEAD_DFLT.
- Sub-module piezo_deadtime handles dead-time insertion.
  - Inputs: clk, rst, drive_t.
  - Outputs: piezo, piezo_n.
  - Contains the DEAD counter and the output registers.

Test Plan:
- Reset: hold rst 3 cycles. Required: piezo=piezo_n=busy=note_done=0 and note_rdy=0 throughout; note_rdy=1 in the cycle after rst falls.
- Single note, FAST_SIM=0, DEAD=4, period=20, dur=100, accepted in cycle 0. Required:
  - busy=1 from cycle 1.
  - piezo=1 in cycles 5..10, both low in 11..14, piezo_n=1 in 15..20.
  - note_done in cycle 100; busy=0 and outputs 0 in cycle 101.
- Back-to-back: queue period=20/dur=100, then period=30/dur=60. Required:
  - note_rdy=0 while the buffer is full.
  - Second note has pcnt=0 in cycle 101.
  - note_done in cycles 100 and 160.
  - piezo and piezo_n are never both 1.
- Rest: period=0, dur=50. Required: outputs stay 0, busy=1 in cycles 1..50, note_done in cycle 50.
- Abort: stop=1 in cycle 37 of a playing note, with one note buffered and note_vld=1. Required: in cycle 38 busy=0, outputs 0 and no note_done; the buffered note and the offered note are both dropped.
- FAST_SIM=1, dur=100, period=20. Required: dcnt reaches 96 in cycle 7, note_done in cycle 7, busy=0 in cycle 8.

Source files
------------

// File: rtl/piezo_pkg.sv
// piezo_pkg: shared types and default sizes for the piezo output stage.
//   drv_state_t : note FSM states (IDLE, PLAY)
//   drive_t     : requested bridge drive (OFF, HI, LO)
//   *_DFLT      : default widths and dead-time used by the modules
package piezo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } drv_state_t;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        HI  = 2'd1,
        LO  = 2'd2
    } drive_t;

    localparam int PERIOD_W_DFLT = 15;
    localparam int DUR_W_DFLT    = 24;
    localparam int DEAD_DFLT     = 4;

endpackage

// File: rtl/piezo_drv_if.sv
// piezo_drv_if: note request handshake plus piezo status/drive signals.
//   master : tune sequencer side (drives note_vld/period/dur/stop)
//   slave  : piezo driver side (drives note_rdy, piezo, piezo_n, busy, note_done)
interface piezo_drv_if
    import piezo_pkg::*;
#(
    parameter int PERIOD_W = PERIOD_W_DFLT,
    parameter int DUR_W    = DUR_W_DFLT
);
    logic                note_vld;
    logic                note_rdy;
    logic [PERIOD_W-1:0] note_period;
    logic [DUR_W-1:0]    note_dur;
    logic                stop;
    logic                piezo;
    logic                piezo_n;
    logic                busy;
    logic                note_done;

    modport master (
        output note_vld, note_period, note_dur, stop,
        input  note_rdy, piezo, piezo_n, busy, note_done
    );

    modport slave (
        input  note_vld, note_period, note_dur, stop,
        output note_rdy, piezo, piezo_n, busy, note_done
    );
endinterface

// File: rtl/piezo_deadtime.sv
// piezo_deadtime: break-before-make stage for the complementary piezo drive.
//   clk, rst   : clock and synchronous active-high reset
//   drv_i      : drive requested for the NEXT cycle
//   piezo_o    : registered high-side drive
//   piezo_n_o  : registered low-side drive
// A drive is only passed through once it has been requested for DEAD+1
// consecutive cycles, so every change leaves both outputs low for DEAD cycles.
module piezo_deadtime
    import piezo_pkg::*;
#(
    parameter int DEAD = DEAD_DFLT
) (
    input  logic   clk,
    input  logic   rst,
    input  drive_t drv_i,
    output logic   piezo_o,
    output logic   piezo_n_o
);
    localparam int            CW     = $clog2(DEAD + 2);
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);

    drive_t        drv_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          piezo_q, piezo_d;
    logic          piezo_n_q, piezo_n_d;

    // cnt_d = (length of the run of identical requests ending next cycle) - 1,
    // saturated at DEAD; the drive is applied once the run reaches DEAD+1.
    always_comb begin
        cnt_d = cnt_q;
        if (drv_i != drv_q) begin
            cnt_d = '0;
        end else if (cnt_q < DEAD_C) begin
            cnt_d = cnt_q + CW'(1);
        end
        piezo_d   = (cnt_d >= DEAD_C) && (drv_i == HI);
        piezo_n_d = (cnt_d >= DEAD_C) && (drv_i == LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drv_q     <= OFF;
            cnt_q     <= '0;
            piezo_q   <= 1'b0;
            piezo_n_q <= 1'b0;
        end else begin
            drv_q     <= drv_i;
            cnt_q     <= cnt_d;
            piezo_q   <= piezo_d;
            piezo_n_q <= piezo_n_d;
        end
    end

    assign piezo_o   = piezo_q;
    assign piezo_n_o = piezo_n_q;
endmodule

// File: rtl/piezo_drv.sv
// piezo_drv: output stage for the tune sequencer.
//   clk, rst : clock and synchronous active-high reset
//   bus      : piezo_drv_if.slave (note handshake, stop, drive outputs, status)
// Holds one active note plus one buffered note, generates a 50% square wave
// with dead-time on piezo/piezo_n and pulses note_done when a note ends.
module piezo_drv
    import piezo_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1,
    parameter int PERIOD_W = PERIOD_W_DFLT,
    parameter int DUR_W    = DUR_W_DFLT,
    parameter int DEAD     = DEAD_DFLT
) (
    input logic        clk,
    input logic        rst,
    piezo_drv_if.slave bus
);
    localparam logic [DUR_W:0]    STEP     = FAST_SIM ? (DUR_W+1)'(16) : (DUR_W+1)'(1);
    localparam logic [PERIOD_W:0] REST_LIM = (PERIOD_W+1)'(2*DEAD + 2);

    drv_state_t          state_q, state_d;
    logic [PERIOD_W-1:0] act_per_q, act_per_d;
    logic [DUR_W-1:0]    act_dur_q, act_dur_d;
    logic [PERIOD_W-1:0] buf_per_q, buf_per_d;
    logic [DUR_W-1:0]    buf_dur_q, buf_dur_d;
    logic                buf_vld_q, buf_vld_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [DUR_W-1:0]    dcnt_q, dcnt_d;

    logic                accept;
    logic                note_end;
    logic [DUR_W:0]      dsum;
    logic [PERIOD_W:0]   pnext;
    drive_t              drive_nxt;

    assign bus.note_rdy  = !buf_vld_q && !bus.stop && !rst;
    assign accept        = bus.note_vld && bus.note_rdy;
    assign dsum          = {1'b0, dcnt_q} + STEP;
    assign pnext         = {1'b0, pcnt_q} + (PERIOD_W+1)'(1);
    assign note_end      = (state_q == PLAY) && (dsum >= {1'b0, act_dur_q});
    assign bus.note_done = note_end && !bus.stop && !rst;
    assign bus.busy      = (state_q == PLAY);

    // Next-state: stop wins; a finishing note hands over to the buffer, or
    // to a note accepted in the same cycle, so back-to-back notes have no gap.
    always_comb begin
        state_d   = state_q;
        act_per_d = act_per_q;
        act_dur_d = act_dur_q;
        buf_per_d = buf_per_q;
        buf_dur_d = buf_dur_q;
        buf_vld_d = buf_vld_q;
        pcnt_d    = (pnext >= {1'b0, act_per_q}) ? '0 : pnext[PERIOD_W-1:0];
        dcnt_d    = dsum[DUR_W-1:0];
        if (bus.stop) begin
            state_d   = IDLE;
            buf_vld_d = 1'b0;
            pcnt_d    = '0;
            dcnt_d    = '0;
        end else if (state_q == IDLE) begin
            pcnt_d = '0;
            dcnt_d = '0;
            if (accept) begin
                state_d   = PLAY;
                act_per_d = bus.note_period;
                act_dur_d = bus.note_dur;
            end
        end else if (note_end) begin
            pcnt_d = '0;
            dcnt_d = '0;
            if (buf_vld_q) begin
                act_per_d = buf_per_q;
                act_dur_d = buf_dur_q;
                buf_vld_d = 1'b0;
            end else if (accept) begin
                act_per_d = bus.note_period;
                act_dur_d = bus.note_dur;
            end else begin
                state_d = IDLE;
            end
        end else if (accept) begin
            buf_per_d = bus.note_period;
            buf_dur_d = bus.note_dur;
            buf_vld_d = 1'b1;
        end
    end

    // Drive wanted in the next cycle, derived from next-state values so the
    // dead-time stage can register its outputs without adding latency.
    always_comb begin
        drive_nxt = OFF;
        if ((state_d == PLAY) && ({1'b0, act_per_d} >= REST_LIM)) begin
            drive_nxt = (pcnt_d < (act_per_d >> 1)) ? HI : LO;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            act_per_q <= '0;
            act_dur_q <= '0;
            buf_per_q <= '0;
            buf_dur_q <= '0;
            buf_vld_q <= 1'b0;
            pcnt_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            act_per_q <= act_per_d;
            act_dur_q <= act_dur_d;
            buf_per_q <= buf_per_d;
            buf_dur_q <= buf_dur_d;
            buf_vld_q <= buf_vld_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    piezo_deadtime #(
        .DEAD(DEAD)
    ) u_deadtime (
        .clk       (clk),
        .rst       (rst),
        .drv_i     (drive_nxt),
        .piezo_o   (bus.piezo),
        .piezo_n_o (bus.piezo_n)
    );
endmodule

// File: tb/tb_piezo_drv.sv
// tb_piezo_drv: drives two piezo_drv instances (FAST_SIM=0 and FAST_SIM=1)
// with identical stimulus and compares both against a note-queue model.
module tb_piezo_drv;
    localparam int DEAD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        vld;
    logic [14:0] per;
    logic [23:0] dur;
    logic        stp;

    int nChecks = 0;
    int nErrors = 0;
    int cycNo   = 0;

    // Model: up to two queued notes per instance, elapsed active cycles of
    // the head note, and the last DEAD+1 requested drives (0 off, 1 hi, 2 lo).
    typedef struct {
        int per;
        int dur;
    } note_t;

    note_t  modelQ[2][2];
    int     modelLen[2];
    longint modelK[2];
    int     driveHist[2][DEAD+1];

    logic sPz[2], sPzn[2], sBusy[2], sRdy[2], sDone[2];

    piezo_drv_if #(.PERIOD_W(15), .DUR_W(24)) if0 ();
    piezo_drv_if #(.PERIOD_W(15), .DUR_W(24)) if1 ();

    assign if0.note_vld    = vld;
    assign if0.note_period = per;
    assign if0.note_dur    = dur;
    assign if0.stop        = stp;
    assign if1.note_vld    = vld;
    assign if1.note_period = per;
    assign if1.note_dur    = dur;
    assign if1.stop        = stp;

    piezo_drv #(.FAST_SIM(1'b0), .PERIOD_W(15), .DUR_W(24), .DEAD(DEAD)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    piezo_drv #(.FAST_SIM(1'b1), .PERIOD_W(15), .DUR_W(24), .DEAD(DEAD)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    // Free-running 100 MHz-style bench clock.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s cycle %0d: got %b required %b", name, cycNo, actual, expected);
        end
    endtask

    // One clock cycle: sample at negedge, compare with the model, advance it.
    task automatic tick();
        longint step;
        logic   act, expRdy, expDone, expPz, expPzn, accepted;
        int     d, p;
        @(negedge clk);
        sPz[0]   = if0.piezo;    sPz[1]   = if1.piezo;
        sPzn[0]  = if0.piezo_n;  sPzn[1]  = if1.piezo_n;
        sBusy[0] = if0.busy;     sBusy[1] = if1.busy;
        sRdy[0]  = if0.note_rdy; sRdy[1]  = if1.note_rdy;
        sDone[0] = if0.note_done; sDone[1] = if1.note_done;
        for (int i = 0; i < 2; i++) begin
            step    = (i == 1) ? 64'sd16 : 64'sd1;
            act     = modelLen[i] > 0;
            expRdy  = !rst && !stp && (modelLen[i] < 2);
            expDone = act && !rst && !stp &&
                      (modelK[i] * step + step >= longint'(modelQ[i][0].dur));
            d = 0;
            if (act && modelQ[i][0].per >= 2*DEAD + 2) begin
                p = modelQ[i][0].per;
                d = ((modelK[i] % longint'(p)) < longint'(p / 2)) ? 1 : 2;
            end
            for (int j = 0; j < DEAD; j++) driveHist[i][j] = driveHist[i][j+1];
            driveHist[i][DEAD] = d;
            expPz  = 1'b1;
            expPzn = 1'b1;
            for (int j = 0; j <= DEAD; j++) begin
                if (driveHist[i][j] != 1) expPz = 1'b0;
                if (driveHist[i][j] != 2) expPzn = 1'b0;
            end
            checkOutput($sformatf("dut%0d_rdy", i), sRdy[i], expRdy);
            checkOutput($sformatf("dut%0d_busy", i), sBusy[i], act);
            checkOutput($sformatf("dut%0d_done", i), sDone[i], expDone);
            checkOutput($sformatf("dut%0d_piezo", i), sPz[i], expPz);
            checkOutput($sformatf("dut%0d_piezo_n", i), sPzn[i], expPzn);
            checkOutput($sformatf("dut%0d_overlap", i), sPz[i] & sPzn[i], 1'b0);

            accepted = vld && expRdy;
            if (rst || stp) begin
                modelLen[i] = 0;
                modelK[i]   = 0;
            end else begin
                if (expDone) begin
                    modelQ[i][0] = modelQ[i][1];
                    modelLen[i]--;
                    modelK[i] = 0;
                end else if (act) begin
                    modelK[i]++;
                end
                if (accepted) begin
                    modelQ[i][modelLen[i]].per = int'(per);
                    modelQ[i][modelLen[i]].dur = int'(dur);
                    modelLen[i]++;
                end
            end
        end
        @(posedge clk);
        #1;
        cycNo++;
    endtask

    task automatic applyStimulus(input logic v, input int p, input int d, input logic s, input logic r);
        vld = v;
        per = 15'(p);
        dur = 24'(d);
        stp = s;
        rst = r;
        tick();
    endtask

    // Directed scenarios with hand-computed expectations, then random traffic.
    initial begin
        for (int i = 0; i < 2; i++) begin
            modelLen[i] = 0;
            modelK[i]   = 0;
            for (int j = 0; j <= DEAD; j++) driveHist[i][j] = 0;
        end
        vld = 1'b0; per = '0; dur = '0; stp = 1'b0; rst = 1'b1;

        // Reset held for three cycles
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b1);
            checkOutput("rst_rdy", sRdy[0], 1'b0);
            checkOutput("rst_busy", sBusy[0], 1'b0);
            checkOutput("rst_outputs", sPz[0] | sPzn[0] | sDone[0], 1'b0);
        end
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        checkOutput("rst_release_rdy", sRdy[0], 1'b1);

        // Single note period=20 dur=100 accepted in cycle 0
        $display("[TB] single note");
        applyStimulus(1'b1, 20, 100, 1'b0, 1'b0);
        for (int c = 1; c <= 105; c++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
            if (c == 1)  checkOutput("single_busy_c1", sBusy[0], 1'b1);
            if (c == 4)  checkOutput("single_pz_c4", sPz[0], 1'b0);
            if (c == 5)  checkOutput("single_pz_c5", sPz[0], 1'b1);
            if (c == 10) checkOutput("single_pz_c10", sPz[0], 1'b1);
            if (c == 11) checkOutput("single_dead_c11", sPz[0] | sPzn[0], 1'b0);
            if (c == 14) checkOutput("single_pzn_c14", sPzn[0], 1'b0);
            if (c == 15) checkOutput("single_pzn_c15", sPzn[0], 1'b1);
            if (c == 20) checkOutput("single_pzn_c20", sPzn[0], 1'b1);
            if (c == 7)  checkOutput("fast_done_c7", sDone[1], 1'b1);
            if (c == 8)  checkOutput("fast_busy_c8", sBusy[1], 1'b0);
            if (c == 99) checkOutput("single_done_c99", sDone[0], 1'b0);
            if (c == 100) checkOutput("single_done_c100", sDone[0], 1'b1);
            if (c == 101) begin
                checkOutput("single_busy_c101", sBusy[0], 1'b0);
                checkOutput("single_out_c101", sPz[0] | sPzn[0], 1'b0);
            end
        end

        // Back-to-back: 20/100 then 30/60, third offer refused while full
        $display("[TB] back-to-back");
        applyStimulus(1'b1, 20, 100, 1'b0, 1'b0);
        applyStimulus(1'b1, 30, 60, 1'b0, 1'b0);
        for (int c = 2; c <= 170; c++) begin
            applyStimulus(c <= 5, 25, 40, 1'b0, 1'b0);
            if (c == 2)   checkOutput("b2b_rdy_full_c2", sRdy[0], 1'b0);
            if (c == 50)  checkOutput("b2b_rdy_full_c50", sRdy[0], 1'b0);
            if (c == 100) checkOutput("b2b_done_c100", sDone[0], 1'b1);
            if (c == 101) begin
                checkOutput("b2b_busy_c101", sBusy[0], 1'b1);
                checkOutput("b2b_dead_c101", sPz[0], 1'b0);
            end
            if (c == 105) checkOutput("b2b_pz_c105", sPz[0], 1'b1);
            if (c == 159) checkOutput("b2b_done_c159", sDone[0], 1'b0);
            if (c == 160) checkOutput("b2b_done_c160", sDone[0], 1'b1);
            if (c == 161) checkOutput("b2b_busy_c161", sBusy[0], 1'b0);
        end

        // Rest note period=0 dur=50
        $display("[TB] rest");
        applyStimulus(1'b1, 0, 50, 1'b0, 1'b0);
        for (int c = 1; c <= 55; c++) begin
            applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
            if (c == 1)  checkOutput("rest_busy_c1", sBusy[0], 1'b1);
            if (c == 25) checkOutput("rest_out_c25", sPz[0] | sPzn[0], 1'b0);
            if (c == 50) checkOutput("rest_done_c50", sDone[0], 1'b1);
            if (c == 51) checkOutput("rest_busy_c51", sBusy[0], 1'b0);
        end

        // Abort in cycle 37 with a buffered note and a concurrent offer
        $display("[TB] abort");
        applyStimulus(1'b1, 20, 100, 1'b0, 1'b0);
        applyStimulus(1'b1, 30, 60, 1'b0, 1'b0);
        for (int c = 2; c <= 45; c++) begin
            applyStimulus(c == 37, 25, 40, c == 37, 1'b0);
            if (c == 37) checkOutput("abort_rdy_c37", sRdy[0], 1'b0);
            if (c == 38) begin
                checkOutput("abort_busy_c38", sBusy[0], 1'b0);
                checkOutput("abort_out_c38", sPz[0] | sPzn[0], 1'b0);
                checkOutput("abort_done_c38", sDone[0], 1'b0);
            end
            if (c == 40) checkOutput("abort_dropped_c40", sBusy[0], 1'b0);
        end

        // Randomized traffic including rests, odd periods, stop and reset
        $display("[TB] random");
        for (int n = 0; n < 3000; n++) begin
            int rp;
            rp = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 9)) : int'($urandom_range(10, 40));
            applyStimulus($urandom_range(0, 2) != 0, rp, int'($urandom_range(0, 150)),
                          $urandom_range(0, 63) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
